shift_reg4: RTL and testbench
=============================

SHIFT_REG4 -- requirements
Module: shift_reg4

Interface
REQ-001 Parameters: none; depth is fixed at 4 stages.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 Ports (name, direction, width, meaning):
- clock, input, 1, single clock; all state updates on rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- shift_in, input, 1, serial data in; sampled on each rising clock edge.
- shift_out, output, 1, serial data out; always equals stage bit3.
- parallel_out, output, 4, {bit3,bit2,bit1,bit0}; read-only tap of all stages.
REQ-004 State SHALL be held in four separately named 1-bit registers bit0, bit1, bit2, bit3.
- Names are fixed so benches can preset them hierarchically at time 0.

Function
REQ-005 On every rising clock edge with reset_n high, all four stages SHALL update simultaneously:
- bit0 <= shift_in
- bit1 <= bit0
- bit2 <= bit1
- bit3 <= bit2
REQ-006 There is no enable: the register SHALL shift on every rising edge.
REQ-007 shift_out SHALL be driven combinationally from bit3 (no extra register).
REQ-008 parallel_out SHALL be driven combinationally from the stages, with bit3 as the MSB.
REQ-009 Latency: a value sampled on shift_in at rising edge N SHALL appear on shift_out immediately after edge N+3 and SHALL hold until edge N+4.
- This is a 4-edge delay counted inclusively of the sampling edge.
REQ-010 shift_in changes between edges SHALL have no effect until the next rising edge.
REQ-011 Outputs SHALL never be X once reset has been applied or the stages have been preset.

Reset
REQ-012 While reset_n is low, bit0..bit3 SHALL be 0, shift_out SHALL be 0 and parallel_out SHALL be 4'b0000, independent of clock.
REQ-013 Reset assertion SHALL take effect immediately (asynchronous), including mid-stream, and SHALL discard all shifted data.
REQ-014 After reset_n rises, the first rising edge SHALL load shift_in into bit0; the other stages shift in the reset zeros.
REQ-015 Holding reset_n high from time 0, with stages initialised by hierarchical assignment, SHALL be a supported mode of operation.

Structure
REQ-016 No shared package is required; no typedefs or constants need to be exported.
REQ-017 A single sub-module, shift_stage, SHALL be used for each stage:
- contents: one D flip-flop with asynchronous active-low reset to 0;
- ports: clock, reset_n, d, q.
REQ-018 Four shift_stage instances SHALL be chained, and their q outputs SHALL be the nets bit0..bit3.
- If hierarchical preset of the instance flops is not possible in the chosen flow, the stages SHALL instead be coded inline as registers with these names.

Verification
REQ-019 Reset check:
- stimulus: preset any pattern, assert reset_n low between edges;
- response: shift_out=0 and parallel_out=0000 immediately, with no clock edge needed.
REQ-020 Single pulse:
- stimulus: stages 0000; shift_in=1 for exactly one edge, then 0;
- response: parallel_out goes 0001, 0010, 0100, 1000, 0000 on successive edges;
- response: shift_out is 1 for exactly one cycle, after the 4th edge.
REQ-021 Alternating stream:
- stimulus: clock period 10, rising edges at 5, 15, 25, ...; stages preset to 0; shift_in=0 at t=0, then toggles 1,0,1,0,1,0 at t=10,20,...,60;
- response: shift_out equals shift_in delayed by 4 edges: 0 through t=45, then 1,0,1,0,1,0 on the edges at 45, 55, ..., 95, then 0 through t=100.
REQ-022 Preset check:
- stimulus: force bit0..bit3 = 1,0,1,1 at t=0 with shift_in=0;
- response: shift_out reads 1,1,0,1 after edges 0..3, then 0 thereafter.
REQ-023 Mid-stream reset:
- stimulus: shift 1111 in, assert reset_n low for 3 ns between edges, release, shift_in=1;
- response: parallel_out=0000 during reset, then 0001 after the next edge.
REQ-024 Mid-cycle glitch:
- stimulus: toggle shift_in 0->1->0 entirely between two rising edges;
- response: parallel_out is unchanged at the next edge (0 shifted in).

Source files
------------

// File: rtl/shift_reg4_pkg.sv
// Shared constants for the 4-stage serial-in/parallel-out shift register.
package shift_reg4_pkg;
  localparam int DEPTH = 4;
endpackage

// File: rtl/shift_stage.sv
// One stage of the shift chain: a single D flop, async active-low reset to 0.
module shift_stage (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic r_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_q <= 1'b0;
    else          r_q <= d;
  end

  assign q = r_q;

endmodule

// File: rtl/shift_reg4.sv
// Four-stage serial-in shift register with serial and parallel taps.
module shift_reg4
  import shift_reg4_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             shift_in,
  output logic             shift_out,
  output logic [DEPTH-1:0] parallel_out
);

  logic bit0;
  logic bit1;
  logic bit2;
  logic bit3;

  shift_stage u_bit0 (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (shift_in),
    .q       (bit0)
  );

  shift_stage u_bit1 (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (bit0),
    .q       (bit1)
  );

  shift_stage u_bit2 (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (bit1),
    .q       (bit2)
  );

  shift_stage u_bit3 (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (bit2),
    .q       (bit3)
  );

  assign shift_out    = bit3;
  assign parallel_out = {bit3, bit2, bit1, bit0};

endmodule

// File: tb/tb_shift_reg4.sv
// Bench for shift_reg4: queue-based model checked every negedge plus directed literals.
module tb_shift_reg4;

  logic       clock;
  logic       reset_n;
  logic       shift_in;
  logic       shift_out;
  logic [3:0] parallel_out;

  int n_pass;
  int n_total;
  bit mdl_on;

  // hist[0] is the newest sampled bit (bit0), hist[3] the oldest (bit3)
  bit hist[$];

  shift_reg4 dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .shift_in     (shift_in),
    .shift_out    (shift_out),
    .parallel_out (parallel_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [3:0] act,
                     input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b at t=%0t", name, act, exp, $time);
  endtask

  function automatic logic [3:0] mdl_par();
    return {hist[3], hist[2], hist[1], hist[0]};
  endfunction

  task automatic mdl_set(input bit b0, input bit b1, input bit b2, input bit b3);
    hist = '{b0, b1, b2, b3};
  endtask

  always @(posedge clock) begin
    if (reset_n === 1'b1) begin
      hist.push_front(shift_in);
      void'(hist.pop_back());
    end
  end

  always @(negedge reset_n) mdl_set(0, 0, 0, 0);

  always @(negedge clock) begin
    if (mdl_on) begin
      chk("model_par", parallel_out, mdl_par());
      chk("model_sout", {3'b000, shift_out}, {3'b000, hist[3]});
    end
  end

  task automatic preset(input bit b0, input bit b1, input bit b2, input bit b3);
    dut.u_bit0.r_q = b0;
    dut.u_bit1.r_q = b1;
    dut.u_bit2.r_q = b2;
    dut.u_bit3.r_q = b3;
    mdl_set(b0, b1, b2, b3);
  endtask

  logic alt_in  [11];
  logic alt_exp [11];

  initial begin
    #20000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    alt_in  = '{1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    alt_exp = '{0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0};
    n_pass  = 0;
    n_total = 0;
    mdl_on  = 1'b0;
    reset_n  = 1'b1;
    shift_in = 1'b0;

    // preset bit0..bit3 = 1,0,1,1 with reset held high from time 0
    preset(1, 0, 1, 1);
    mdl_on = 1'b1;
    #1;
    chk("preset_par", parallel_out, 4'b1101);
    chk("preset_sout0", {3'b0, shift_out}, 4'd1);
    @(negedge clock);
    chk("preset_sout1", {3'b0, shift_out}, 4'd1);
    chk("preset_par1", parallel_out, 4'b1010);
    @(negedge clock);
    chk("preset_sout2", {3'b0, shift_out}, 4'd0);
    @(negedge clock);
    chk("preset_sout3", {3'b0, shift_out}, 4'd1);
    @(negedge clock);
    chk("preset_sout4", {3'b0, shift_out}, 4'd0);

    // async reset between edges, no clock needed (t=40 here)
    #2 preset(0, 1, 1, 0);
    #1 chk("pre_reset_par", parallel_out, 4'b0110);
    reset_n = 1'b0;
    #1 chk("async_rst_par", parallel_out, 4'b0000);
    chk("async_rst_sout", {3'b0, shift_out}, 4'd0);
    shift_in = 1'b1;
    #3 chk("rst_hold_par", parallel_out, 4'b0000);
    #1 reset_n = 1'b1;
    @(posedge clock) #1;
    chk("first_load", parallel_out, 4'b0001);

    // fill with 1111 then reset mid-stream for 3 ns
    repeat (3) @(posedge clock);
    #1 chk("fill_1111", parallel_out, 4'b1111);
    #1 reset_n = 1'b0;
    #1 chk("mid_rst_par", parallel_out, 4'b0000);
    #2 reset_n = 1'b1;
    @(posedge clock) #1;
    chk("mid_rst_after", parallel_out, 4'b0001);

    // single pulse from a cleared register
    #1 reset_n = 1'b0;
    #1 reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock) #1;
      shift_in = 1'b0;
      chk($sformatf("pulse_par%0d", k), parallel_out,
          (k < 4) ? 4'(1 << k) : 4'b0000);
      chk($sformatf("pulse_sout%0d", k), {3'b0, shift_out},
          (k == 3) ? 4'd1 : 4'd0);
    end

    // alternating stream from cleared stages
    @(negedge clock);
    reset_n = 1'b0;
    #1 reset_n = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(negedge clock);
      if (k > 0)
        chk($sformatf("alt_sout%0d", k), {3'b0, shift_out}, {3'b0, alt_exp[k]});
      shift_in = alt_in[k];
    end

    // load 0001, then glitch shift_in entirely between edges
    @(negedge clock);
    chk("alt_drain", parallel_out, 4'b0000);
    shift_in = 1'b1;
    @(posedge clock) #2;
    shift_in = 1'b0;
    chk("glitch_pre", parallel_out, 4'b0001);
    #1 shift_in = 1'b1;
    #2 shift_in = 1'b0;
    @(posedge clock) #1;
    chk("glitch_post", parallel_out, 4'b0010);

    @(negedge clock);
    mdl_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
